// File: rtl/alu_bitcount_unit.sv
// ---------------------------------------------------------------------------
// alu_bitcount_unit
//
// Iterative execution unit for the bit-counting operators ff1, fl1, cnt and
// clb. It sits beside the single-cycle ALU in the execute stage. Each BUSY
// cycle it scans one CHUNK-bit slice of the operand, so a full result takes
// N = WIDTH/CHUNK BUSY cycles followed by a DONE state that holds the result
// until the consumer takes it.
//
// Ports:
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset
//   flush_i         kills any in-flight or pending operation
//   valid_i         issue request
//   ready_o         unit is IDLE and can accept an operation
//   operator_i      operation code (alu_op)
//   operand_i       source operand rs1
//   result_valid_o  result available (DONE state)
//   result_ready_i  consumer takes the result
//   result_o        zero-extended count
//   illegal_o       operator was not ff1/fl1/cnt/clb, qualified by result_valid_o
// ---------------------------------------------------------------------------

package alu_bitcount_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_XOR  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_AND  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9,
      ALU_FF1  = 4'd10,
      ALU_FL1  = 4'd11,
      ALU_CNT  = 4'd12,
      ALU_CLB  = 4'd13
   } alu_op;

endpackage

module alu_bitcount_unit
   import alu_bitcount_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  alu_op            operator_i,
   input  logic [WIDTH-1:0] operand_i,
   output logic             result_valid_o,
   input  logic             result_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             illegal_o
);

   localparam int unsigned N  = WIDTH / CHUNK;
   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam int unsigned NW = (N > 1) ? $clog2(N) : 1;
   localparam logic [NW-1:0] LAST = NW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q,    state_d;
   alu_op            operator_q, operator_d;
   logic [WIDTH-1:0] operand_q,  operand_d;
   logic [NW-1:0]    chunkCnt_q, chunkCnt_d;
   logic [CW-1:0]    acc_q,      acc_d;
   logic             found_q,    found_d;
   logic [WIDTH-1:0] result_q,   result_d;
   logic             illegal_q,  illegal_d;

   logic [NW-1:0]    sliceIdx;
   logic [CHUNK-1:0] chunk;
   logic [CW-1:0]    sliceBase;
   logic [CW-1:0]    popCnt;
   logic [CW-1:0]    lowIdx;
   logic [CW-1:0]    highIdx;
   logic [CW-1:0]    runLen;
   logic             anyOne;
   logic             runBroken;
   logic [CW-1:0]    finalVal;

   // Slice selection and per-slice analysis. ff1, fl1 and cnt walk the
   // operand from the LSB slice upwards; clb walks from the MSB slice
   // downwards because it measures a run that starts at the sign bit.
   // The slice is picked by comparing against every constant slice index,
   // which keeps all part-selects static.
   always_comb begin
      sliceIdx  = (operator_q == ALU_CLB) ? (LAST - chunkCnt_q) : chunkCnt_q;
      chunk     = '0;
      sliceBase = '0;
      for (int unsigned s = 0; s < N; s++) begin
         if (NW'(s) == sliceIdx) begin
            chunk     = operand_q[s*CHUNK +: CHUNK];
            sliceBase = CW'(s * CHUNK);
         end
      end

      popCnt = '0;
      for (int unsigned i = 0; i < CHUNK; i++) begin
         popCnt = popCnt + CW'(chunk[i]);
      end

      anyOne = |chunk;

      lowIdx = '0;
      for (int i = CHUNK - 1; i >= 0; i--) begin
         if (chunk[i]) lowIdx = CW'(i);
      end

      highIdx = '0;
      for (int i = 0; i < CHUNK; i++) begin
         if (chunk[i]) highIdx = CW'(i);
      end

      // Length of the run of sign-equal bits starting at the top of this
      // slice; runBroken marks that the run ended inside the slice.
      runLen    = '0;
      runBroken = 1'b0;
      for (int i = CHUNK - 1; i >= 0; i--) begin
         if (!runBroken) begin
            if (chunk[i] == operand_q[WIDTH-1]) begin
               runLen = runLen + CW'(1);
            end else begin
               runBroken = 1'b1;
            end
         end
      end
   end

   // Next-state logic. Flush beats both accept and the result handshake.
   // In BUSY the accumulator is updated per operator; found_q tracks whether
   // a set bit was seen (ff1/fl1) or the sign run has ended (clb). On the
   // last slice the final value is formed from the updated accumulator and
   // latched into the result register as the FSM enters DONE.
   always_comb begin
      state_d    = state_q;
      operator_d = operator_q;
      operand_d  = operand_q;
      chunkCnt_d = chunkCnt_q;
      acc_d      = acc_q;
      found_d    = found_q;
      result_d   = result_q;
      illegal_d  = illegal_q;
      finalVal   = '0;

      unique case (state_q)
         IDLE: begin
            if (valid_i && !flush_i) begin
               operator_d = operator_i;
               operand_d  = operand_i;
               chunkCnt_d = '0;
               acc_d      = '0;
               found_d    = 1'b0;
               state_d    = BUSY;
            end
         end

         BUSY: begin
            if (flush_i) begin
               state_d = IDLE;
            end else begin
               case (operator_q)
                  ALU_CNT: acc_d = acc_q + popCnt;
                  ALU_FF1: begin
                     if (!found_q && anyOne) begin
                        acc_d   = sliceBase + lowIdx;
                        found_d = 1'b1;
                     end
                  end
                  ALU_FL1: begin
                     if (anyOne) begin
                        acc_d   = sliceBase + highIdx;
                        found_d = 1'b1;
                     end
                  end
                  ALU_CLB: begin
                     if (!found_q) begin
                        acc_d   = acc_q + runLen;
                        found_d = runBroken;
                     end
                  end
                  default: ;
               endcase

               chunkCnt_d = chunkCnt_q + NW'(1);

               if (chunkCnt_q == LAST) begin
                  illegal_d = 1'b0;
                  case (operator_q)
                     ALU_CNT: finalVal = acc_d;
                     ALU_FF1,
                     ALU_FL1: finalVal = found_d ? acc_d : CW'(WIDTH);
                     ALU_CLB: finalVal = (operand_q == '0) ? '0 : (acc_d - CW'(1));
                     default: begin
                        finalVal  = '0;
                        illegal_d = 1'b1;
                     end
                  endcase
                  result_d = {{(WIDTH-CW){1'b0}}, finalVal};
                  state_d  = DONE;
               end
            end
         end

         DONE: begin
            if (flush_i || result_ready_i) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         operator_q <= ALU_ADD;
         operand_q  <= '0;
         chunkCnt_q <= '0;
         acc_q      <= '0;
         found_q    <= 1'b0;
         result_q   <= '0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         operator_q <= operator_d;
         operand_q  <= operand_d;
         chunkCnt_q <= chunkCnt_d;
         acc_q      <= acc_d;
         found_q    <= found_d;
         result_q   <= result_d;
         illegal_q  <= illegal_d;
      end
   end

   // Handshake outputs follow the state directly; result and illegal flag
   // come straight from their registers so they hold outside DONE.
   always_comb begin
      ready_o        = (state_q == IDLE);
      result_valid_o = (state_q == DONE);
      result_o       = result_q;
      illegal_o      = illegal_q;
   end

endmodule
